// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared types and constants for the branch trace buffer
// State encoding, trace modes, APB register offsets, CTRL bit positions and
// the word layout of one 16-byte trace entry in the RAM window.
package cpu_trace_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, RUN = 3'd2, DONE = 3'd3, FULL = 3'd4} state_e;
  localparam logic [2:0] MODE_FREE = 3'd0;
  localparam logic [2:0] MODE_WIN = 3'd1;
  localparam logic [2:0] MODE_STOP = 3'd2;
  localparam logic [2:0] MODE_REARM = 3'd3;
  localparam logic [7:0] REG_CTRL = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_WPTR = 8'h08;
  localparam logic [7:0] REG_DROPPED = 8'h0C;
  localparam logic [7:0] REG_TRIG_START = 8'h10;
  localparam logic [7:0] REG_TRIG_END = 8'h14;
  localparam int TRIG_STRIDE = 8;
  localparam int CTRL_EN = 31;
  localparam int CTRL_WRAP = 16;
  localparam int CTRL_CLR = 8;
  localparam logic [1:0] W_SRC = 2'd0;
  localparam logic [1:0] W_DST = 2'd1;
  localparam logic [1:0] W_CNT = 2'd2;
  localparam logic [1:0] W_TS = 2'd3;
  function automatic logic [2:0] eff_mode(input logic [2:0] m);
    return m > MODE_REARM ? MODE_FREE : m;
  endfunction
endpackage

// File: rtl/cpu_branch_trace_buf_if.sv
// cpu_branch_trace_buf_if: APB bus bundle for the trace buffer
// master drives psel/penable/pwrite/paddr/pwdata; slave returns
// prdata/pready/pslverr.
interface cpu_branch_trace_buf_if;
  logic psel;
  logic penable;
  logic pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic pready;
  logic pslverr;
  modport master(output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
  modport slave(input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/cpu_trace_trig_cmp.sv
// cpu_trace_trig_cmp: NUM_TRIG start/end address comparators
// start_i/end_i: comparator addresses; src_i/dst_i: current branch PCs;
// start_hit_o: dst matches any start; end_hit_o: src matches any end.
module cpu_trace_trig_cmp #(
  parameter int PC_WIDTH = 32,
  parameter int NUM_TRIG = 2
) (
  input  logic [PC_WIDTH-1:0] start_i [NUM_TRIG],
  input  logic [PC_WIDTH-1:0] end_i [NUM_TRIG],
  input  logic [PC_WIDTH-1:0] src_i,
  input  logic [PC_WIDTH-1:0] dst_i,
  output logic                start_hit_o,
  output logic                end_hit_o
);
  always_comb begin
    start_hit_o = 1'b0;
    end_hit_o = 1'b0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      start_hit_o |= dst_i == start_i[i];
      end_hit_o |= src_i == end_i[i];
    end
  end
endmodule

// File: rtl/cpu_branch_trace_buf.sv
// cpu_branch_trace_buf: taken-branch trace RAM with repeat compression and APB access
// clk_i/rstn_i: clock, async active-low reset; cpu_rst_i: blocks capture;
// apb: register window (paddr[16]=1) and RAM window (paddr[16]=0), 2 wait states;
// br_valid_i/br_src_i/br_dst_i: taken branch; trig_o: pulse per write or
// repeat increment; full_o: stopped full. TRACE_TIMESTAMP_EN adds a cycle
// timestamp in entry word3.
module cpu_branch_trace_buf import cpu_trace_pkg::*; #(
  parameter int TRACE_DEPTH = 1024,
  parameter int PC_WIDTH = 32,
  parameter int CNT_WIDTH = 16,
  parameter int NUM_TRIG = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cpu_rst_i,
  cpu_branch_trace_buf_if.slave apb,
  input  logic                  br_valid_i,
  input  logic [PC_WIDTH-1:0]   br_src_i,
  input  logic [PC_WIDTH-1:0]   br_dst_i,
  output logic                  trig_o,
  output logic                  full_o
);
  localparam int AW = $clog2(TRACE_DEPTH);
  logic [PC_WIDTH-1:0] src_mem [TRACE_DEPTH];
  logic [PC_WIDTH-1:0] dst_mem [TRACE_DEPTH];
  logic [CNT_WIDTH-1:0] cnt_mem [TRACE_DEPTH];
  logic [PC_WIDTH-1:0] trig_start_q [NUM_TRIG];
  logic [PC_WIDTH-1:0] trig_end_q [NUM_TRIG];
  logic en_q, wrap_q;
  logic [2:0] mode_q, m;
  state_e state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, last_ptr_q, ra;
  logic wrapped_q, wrapped_d, last_vld_q, last_vld_d;
  logic [31:0] dropped_q, dropped_d;
  logic [PC_WIDTH-1:0] last_src_q, last_dst_q;
  logic [CNT_WIDTH-1:0] last_cnt_q, cnt_inc;
  logic trig_q;
  logic wcnt_q, pready_q, pslverr_q;
  logic [31:0] prdata_q, reg_rd, ram_rd, ts_word, rdata;
  logic [7:0] off;
  logic acc, fire, reg_hit, ram_ok, err, wr, wr_ctrl, clr;
  logic v, start_hit, end_hit, same, rec, new_ent, inc, wrap_pt, full_hit;
  logic unused_paddr;
  assign unused_paddr = ^apb.paddr[31:17];
  cpu_trace_trig_cmp #(.PC_WIDTH(PC_WIDTH), .NUM_TRIG(NUM_TRIG)) u_cmp (
    .start_i(trig_start_q), .end_i(trig_end_q), .src_i(br_src_i), .dst_i(br_dst_i),
    .start_hit_o(start_hit), .end_hit_o(end_hit)
  );
  // pready is registered off the second access cycle so it shows in the third
  assign acc = apb.psel & apb.penable & ~pready_q;
  assign fire = acc & wcnt_q;
  assign off = apb.paddr[7:0];
  assign ra = AW'(apb.paddr[15:4]);
  assign ram_ok = {20'd0, apb.paddr[15:4]} < 32'(TRACE_DEPTH);
  assign err = apb.paddr[16] ? ~reg_hit : ~ram_ok | apb.pwrite;
  assign rdata = apb.paddr[16] ? reg_rd : ram_rd;
  assign wr = fire & apb.pwrite & apb.paddr[16] & reg_hit;
  assign wr_ctrl = wr & (off == REG_CTRL);
  assign clr = wr_ctrl & apb.pwdata[CTRL_CLR];
  always_comb begin
    reg_rd = '0;
    reg_hit = 1'b1;
    case (off)
      REG_CTRL: reg_rd = {en_q, 14'd0, wrap_q, 13'd0, mode_q};
      REG_STATUS: reg_rd = {27'd0, wrapped_q, 1'b0, state_q};
      REG_WPTR: reg_rd = 32'(wptr_q);
      REG_DROPPED: reg_rd = dropped_q;
      default: reg_hit = 1'b0;
    endcase
    for (int i = 0; i < NUM_TRIG; i++) begin
      if (off == 8'(REG_TRIG_START + TRIG_STRIDE * i)) begin
        reg_hit = 1'b1;
        reg_rd = 32'(trig_start_q[i]);
      end
      if (off == 8'(REG_TRIG_END + TRIG_STRIDE * i)) begin
        reg_hit = 1'b1;
        reg_rd = 32'(trig_end_q[i]);
      end
    end
  end
  assign ram_rd = apb.paddr[3:2] == W_SRC ? 32'(src_mem[ra]) :
                  apb.paddr[3:2] == W_DST ? 32'(dst_mem[ra]) :
                  apb.paddr[3:2] == W_CNT ? 32'(cnt_mem[ra]) : ts_word;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wcnt_q <= 1'b0;
      pready_q <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q <= '0;
      en_q <= 1'b0;
      wrap_q <= 1'b0;
      mode_q <= '0;
      for (int i = 0; i < NUM_TRIG; i++) begin
        trig_start_q[i] <= '0;
        trig_end_q[i] <= '0;
      end
    end else begin
      wcnt_q <= acc & ~wcnt_q;
      pready_q <= fire;
      pslverr_q <= fire & err;
      prdata_q <= fire && !apb.pwrite && !err ? rdata : '0;
      if (wr_ctrl) begin
        en_q <= apb.pwdata[CTRL_EN];
        wrap_q <= apb.pwdata[CTRL_WRAP];
        mode_q <= apb.pwdata[2:0];
      end
      for (int i = 0; i < NUM_TRIG; i++) begin
        if (wr && off == 8'(REG_TRIG_START + TRIG_STRIDE * i)) trig_start_q[i] <= apb.pwdata[PC_WIDTH-1:0];
        if (wr && off == 8'(REG_TRIG_END + TRIG_STRIDE * i)) trig_end_q[i] <= apb.pwdata[PC_WIDTH-1:0];
      end
    end
  end
  assign apb.prdata = prdata_q;
  assign apb.pready = pready_q;
  assign apb.pslverr = pslverr_q;
  // capture sees the CTRL value from before any same-cycle register write
  assign m = eff_mode(mode_q);
  assign v = br_valid_i & ~cpu_rst_i;
  assign same = last_vld_q && br_src_i == last_src_q && br_dst_i == last_dst_q;
  assign rec = v && (state_q == RUN || (state_q == ARMED && start_hit));
  assign new_ent = rec & ~same;
  assign inc = rec & same;
  assign wrap_pt = wptr_q == AW'(TRACE_DEPTH - 1);
  assign full_hit = new_ent & wrap_pt & ~wrap_q;
  assign cnt_inc = &last_cnt_q ? last_cnt_q : last_cnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    wptr_d = new_ent ? wptr_q + 1'b1 : wptr_q;
    wrapped_d = wrapped_q | (new_ent & wrap_pt & wrap_q);
    last_vld_d = last_vld_q | new_ent;
    dropped_d = v && (state_q == DONE || state_q == FULL) && ~&dropped_q ? dropped_q + 32'd1 : dropped_q;
    case (state_q)
      IDLE: state_d = m == MODE_WIN || m == MODE_REARM ? ARMED : RUN;
      ARMED: state_d = !rec ? ARMED : full_hit ? FULL : RUN;
      RUN: state_d = rec && end_hit && m == MODE_REARM ? ARMED :
                     rec && end_hit && (m == MODE_WIN || m == MODE_STOP) ? DONE :
                     full_hit ? FULL : RUN;
      default: ;
    endcase
    if (!en_q || clr) begin
      state_d = IDLE;
      wptr_d = '0;
      wrapped_d = 1'b0;
      last_vld_d = 1'b0;
    end
    if (clr) dropped_d = '0;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      wptr_q <= '0;
      wrapped_q <= 1'b0;
      last_vld_q <= 1'b0;
      dropped_q <= '0;
      last_ptr_q <= '0;
      last_src_q <= '0;
      last_dst_q <= '0;
      last_cnt_q <= '0;
      trig_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      wrapped_q <= wrapped_d;
      last_vld_q <= last_vld_d;
      dropped_q <= dropped_d;
      trig_q <= rec;
      if (new_ent) begin
        last_ptr_q <= wptr_q;
        last_src_q <= br_src_i;
        last_dst_q <= br_dst_i;
        last_cnt_q <= '0;
      end else if (inc) begin
        last_cnt_q <= cnt_inc;
      end
    end
  end
  // a repeat only bumps the count of the entry written last
  always_ff @(posedge clk_i) begin
    if (new_ent) begin
      src_mem[wptr_q] <= br_src_i;
      dst_mem[wptr_q] <= br_dst_i;
      cnt_mem[wptr_q] <= '0;
    end else if (inc) begin
      cnt_mem[last_ptr_q] <= cnt_inc;
    end
  end
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] ts_mem [TRACE_DEPTH];
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) ts_q <= '0;
    else ts_q <= clr ? '0 : ts_q + 32'd1;
  end
  always_ff @(posedge clk_i) begin
    if (new_ent) ts_mem[wptr_q] <= ts_q;
  end
  assign ts_word = ts_mem[ra];
`else
  assign ts_word = '0;
`endif
  assign trig_o = trig_q;
  assign full_o = state_q == FULL;
endmodule

// File: tb/tb_cpu_branch_trace_buf.sv
// tb_cpu_branch_trace_buf: directed bench for cpu_branch_trace_buf (depth 4, 4-bit counts)
module tb_cpu_branch_trace_buf;
  localparam logic [31:0] CTRL = 32'h0001_0000;
  localparam logic [31:0] STATUS = 32'h0001_0004;
  localparam logic [31:0] WPTR = 32'h0001_0008;
  localparam logic [31:0] DROP = 32'h0001_000C;
  localparam logic [31:0] TS0 = 32'h0001_0010;
  localparam logic [31:0] TE0 = 32'h0001_0014;
  localparam logic [31:0] TS1 = 32'h0001_0018;
  localparam logic [31:0] TE1 = 32'h0001_001C;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic cpu_rst = 1'b0;
  logic br_valid = 1'b0;
  logic [31:0] br_src = '0;
  logic [31:0] br_dst = '0;
  logic trig, full;
  logic [31:0] rd;
  logic rerr;
  int lat;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cpu_branch_trace_buf_if apb();
  cpu_branch_trace_buf #(.TRACE_DEPTH(4), .PC_WIDTH(32), .CNT_WIDTH(4), .NUM_TRIG(2)) dut (
    .clk_i(clk), .rstn_i(rstn), .cpu_rst_i(cpu_rst), .apb(apb),
    .br_valid_i(br_valid), .br_src_i(br_src), .br_dst_i(br_dst),
    .trig_o(trig), .full_o(full)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d);
    apb.psel = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite = w;
    apb.paddr = a;
    apb.pwdata = d;
    @(posedge clk);
    #1 apb.penable = 1'b1;
    for (lat = 2; lat < 20; lat++) begin
      @(posedge clk);
      #1;
      if (apb.pready) break;
    end
    rd = apb.prdata;
    rerr = apb.pslverr;
    if (!apb.pready) begin
      errors++;
      $error("FAIL apb_timeout observed=%0d expected=3", lat);
    end
    @(posedge clk);
    #1 apb.psel = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    xfer(1'b0, a, '0);
    check(tag, rd, exp);
  endtask
  task automatic br(input logic [31:0] s, input logic [31:0] d);
    br_valid = 1'b1;
    br_src = s;
    br_dst = d;
    @(posedge clk);
    #1 br_valid = 1'b0;
  endtask
  initial begin
    apb.psel = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite = 1'b0;
    apb.paddr = '0;
    apb.pwdata = '0;
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_prdata", apb.prdata, 32'd0);
    check("rst_pready", 32'(apb.pready), 32'd0);
    check("rst_pslverr", 32'(apb.pslverr), 32'd0);
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    rd_chk("rst_ctrl", CTRL, 32'd0);
    check("read_latency", 32'(lat), 32'd3);
    check("read_ok_err", 32'(rerr), 32'd0);
    rd_chk("rst_status", STATUS, 32'd0);
    rd_chk("rst_wptr", WPTR, 32'd0);
    xfer(1'b1, CTRL, 32'h8000_0000);
    br(32'h1000, 32'h2000);
    check("trig_pulse", 32'(trig), 32'd1);
    @(posedge clk);
    #1 check("trig_single", 32'(trig), 32'd0);
    for (int k = 1; k < 5; k++) br(32'h1000 + 32'(16 * k), 32'h2000 + 32'(16 * k));
    check("full_o", 32'(full), 32'd1);
    rd_chk("full_status", STATUS, 32'd4);
    rd_chk("full_dropped", DROP, 32'd1);
    rd_chk("full_e0_src", 32'h00, 32'h1000);
    rd_chk("full_e3_dst", 32'h34, 32'h2030);
    rd_chk("full_e2_cnt", 32'h28, 32'd0);
    xfer(1'b1, CTRL, 32'h8001_0100);
    for (int k = 0; k < 6; k++) br(32'h3000 + 32'(16 * k), 32'h4000 + 32'(16 * k));
    rd_chk("wrap_wptr", WPTR, 32'd2);
    rd_chk("wrap_status", STATUS, 32'h12);
    rd_chk("wrap_e0_src", 32'h00, 32'h3040);
    rd_chk("wrap_e1_dst", 32'h14, 32'h4050);
    check("wrap_full", 32'(full), 32'd0);
    xfer(1'b1, CTRL, 32'h8000_0100);
    repeat (10) br(32'h100, 32'h80);
    rd_chk("rep10_cnt", 32'h08, 32'd9);
    rd_chk("rep10_wptr", WPTR, 32'd1);
    repeat (10) br(32'h100, 32'h80);
    rd_chk("rep20_sat", 32'h08, 32'hF);
    rd_chk("rep20_wptr", WPTR, 32'd1);
    rd_chk("word3_zero", 32'h0C, 32'd0);
    xfer(1'b1, TS0, 32'hFFF0);
    xfer(1'b1, TE0, 32'h300);
    xfer(1'b1, TS1, 32'h200);
    xfer(1'b1, TE1, 32'hFFF4);
    rd_chk("trig_start1", TS1, 32'h200);
    xfer(1'b1, CTRL, 32'h8001_0103);
    rd_chk("win_armed", STATUS, 32'd1);
    br(32'h50, 32'h60);
    br(32'h1F0, 32'h200);
    br(32'h300, 32'h400);
    br(32'h410, 32'h420);
    rd_chk("win1_status", STATUS, 32'd1);
    rd_chk("win1_wptr", WPTR, 32'd2);
    br(32'h1F4, 32'h200);
    br(32'h300, 32'h500);
    br(32'h600, 32'h700);
    rd_chk("win2_status", STATUS, 32'h11);
    rd_chk("win2_wptr", WPTR, 32'd0);
    rd_chk("win_e0_src", 32'h00, 32'h1F0);
    rd_chk("win_e1_dst", 32'h14, 32'h400);
    rd_chk("win_e2_src", 32'h20, 32'h1F4);
    rd_chk("win_e3_dst", 32'h34, 32'h500);
    br(32'h300, 32'h200);
    rd_chk("start_wins", STATUS, 32'h12);
    rd_chk("start_wins_e0", 32'h00, 32'h300);
    br(32'h300, 32'h600);
    rd_chk("end_next", STATUS, 32'h11);
    xfer(1'b0, 32'h40, '0);
    check("ram_oor_err", 32'(rerr), 32'd1);
    check("ram_oor_lat", 32'(lat), 32'd3);
    xfer(1'b0, 32'h0001_007C, '0);
    check("reg_7c_err", 32'(rerr), 32'd1);
    check("reg_7c_lat", 32'(lat), 32'd3);
    xfer(1'b0, 32'h0001_0020, '0);
    check("reg_trig2_err", 32'(rerr), 32'd1);
    xfer(1'b1, 32'h10, 32'h1234);
    check("ram_wr_err", 32'(rerr), 32'd1);
    xfer(1'b1, CTRL, 32'h8000_0100);
    rd_chk("clr_wptr", WPTR, 32'd0);
    rd_chk("clr_status", STATUS, 32'd2);
    cpu_rst = 1'b1;
    br(32'h10, 32'h20);
    cpu_rst = 1'b0;
    check("cpu_rst_trig", 32'(trig), 32'd0);
    rd_chk("cpu_rst_wptr", WPTR, 32'd0);
    br(32'h10, 32'h20);
    check("cap_trig", 32'(trig), 32'd1);
    rd_chk("cap_wptr", WPTR, 32'd1);
    xfer(1'b1, CTRL, 32'h8000_0101);
    rd_chk("mode1_armed", STATUS, 32'd1);
    xfer(1'b1, CTRL, 32'h8001_0105);
    rd_chk("mode5_run", STATUS, 32'd2);
    rd_chk("ctrl_readback", CTRL, 32'h8001_0005);
    br(32'h700, 32'h800);
    rd_chk("mode5_wptr", WPTR, 32'd1);
    xfer(1'b1, CTRL, 32'h0);
    rd_chk("dis_status", STATUS, 32'd0);
    rd_chk("dis_wptr", WPTR, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
